// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and sizes for the direct-mapped read-only cache
package cache_pkg;

    localparam int LINES  = 8;
    localparam int WORDS  = 8;
    localparam int TAG_W  = 25;
    localparam int DATA_W = 16;
    localparam int LINE_W = $clog2(LINES);
    localparam int WORD_W = $clog2(WORDS);
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        REFILL,
        RESP
    } cache_state_t;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [LINE_W-1:0] line_id;
        logic [WORD_W-1:0] word_id;
    } cache_req_t;

    // Byte address of one refill beat; words are 2 bytes so bit 0 is always 0.
    function automatic logic [ADDR_W-1:0] refill_addr(
        input logic [TAG_W-1:0]  tag,
        input logic [LINE_W-1:0] line_id,
        input logic [WORD_W-1:0] beat
    );
        return {tag, line_id, beat, 1'b0};
    endfunction

endpackage

// File: rtl/cache_if.sv
// rtl/cache_if.sv - core read port and memory refill port of the cache controller
interface cache_if;
    import cache_pkg::*;

    logic              cpu_req;
    logic [TAG_W-1:0]  cpu_tag;
    logic [LINE_W-1:0] cpu_line_id;
    logic [WORD_W-1:0] cpu_word_id;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ready;
    logic              cpu_busy;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    // Controller side
    modport slave (
        input  cpu_req, cpu_tag, cpu_line_id, cpu_word_id, mem_rdata, mem_ack,
        output cpu_rdata, cpu_ready, cpu_busy, mem_req, mem_addr
    );

    // Core and memory side
    modport master (
        output cpu_req, cpu_tag, cpu_line_id, cpu_word_id, mem_rdata, mem_ack,
        input  cpu_rdata, cpu_ready, cpu_busy, mem_req, mem_addr
    );

endinterface

// File: rtl/cache_store.sv
// rtl/cache_store.sv - tag, valid and data arrays with combinational read
module cache_store
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LINE_W-1:0] rd_line_i,
    input  logic [WORD_W-1:0] rd_word_i,
    output logic              rd_valid_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              wr_en_i,
    input  logic [LINE_W-1:0] wr_line_i,
    input  logic [WORD_W-1:0] wr_word_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              fill_done_i,
    input  logic [TAG_W-1:0]  fill_tag_i,
    input  logic              inval_en_i,
    input  logic [LINE_W-1:0] inval_line_i,
    input  logic              clear_all_i
);

    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  valid_d;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES][WORDS];

    // Valid update: a flush wipes everything, otherwise evict and fill per line
    always_comb begin
        valid_d = valid_q;
        if (inval_en_i) begin
            valid_d[inval_line_i] = 1'b0;
        end
        if (fill_done_i) begin
            valid_d[wr_line_i] = 1'b1;
        end
        if (clear_all_i) begin
            valid_d = '0;
        end
    end

    // Valid bits are the only state that must come out of reset clean
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Data and tag arrays: one refill beat per cycle, tag written with the last beat
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            data_q[wr_line_i][wr_word_i] <= wr_data_i;
        end
        if (fill_done_i) begin
            tag_q[wr_line_i] <= fill_tag_i;
        end
    end

    assign rd_valid_o = valid_q[rd_line_i];
    assign rd_tag_o   = tag_q[rd_line_i];
    assign rd_data_o  = data_q[rd_line_i][rd_word_i];

endmodule

// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - lookup/refill FSM, beat counter and hit/miss statistics
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    cache_if.slave           bus,
    input  logic             flush,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    cache_state_t      state_q;
    cache_req_t        req_q;
    logic              req_hit_q;
    logic [WORD_W-1:0] beat_q;
    logic [WORD_W-1:0] beat_d;
    logic              flush_pending_q;
    logic              cpu_ready_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic              mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [CNT_W-1:0]  hit_cnt_q;
    logic [CNT_W-1:0]  hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q;
    logic [CNT_W-1:0]  miss_cnt_d;

    logic              in_idle;
    logic              flush_now;
    logic              beat_ack;
    logic              last_beat;
    logic [LINE_W-1:0] rd_line;
    logic [WORD_W-1:0] rd_word;
    logic [TAG_W-1:0]  look_tag;
    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [DATA_W-1:0] rd_data;
    logic              look_hit;

    assign in_idle   = (state_q == IDLE);
    assign flush_now = in_idle && (flush || flush_pending_q);
    assign beat_ack  = (state_q == REFILL) && mem_req_q && bus.mem_ack;
    assign last_beat = (beat_q == WORD_W'(WORDS - 1));
    assign beat_d    = beat_q + WORD_W'(1);
    assign hit_cnt_d  = (hit_cnt_q  == '1) ? hit_cnt_q  : hit_cnt_q  + CNT_W'(1);
    assign miss_cnt_d = (miss_cnt_q == '1) ? miss_cnt_q : miss_cnt_q + CNT_W'(1);

    // While idle the store is addressed by the incoming request so the lookup
    // result is registered at the sampling edge and the hit response can be
    // presented during the COMPARE cycle; afterwards it follows the latched request.
    assign rd_line  = in_idle ? bus.cpu_line_id : req_q.line_id;
    assign rd_word  = in_idle ? bus.cpu_word_id : req_q.word_id;
    assign look_tag = in_idle ? bus.cpu_tag     : req_q.tag;
    assign look_hit = rd_valid && (rd_tag == look_tag);

    cache_store u_store (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_line_i    (rd_line),
        .rd_word_i    (rd_word),
        .rd_valid_o   (rd_valid),
        .rd_tag_o     (rd_tag),
        .rd_data_o    (rd_data),
        .wr_en_i      (beat_ack),
        .wr_line_i    (req_q.line_id),
        .wr_word_i    (beat_q),
        .wr_data_i    (bus.mem_rdata),
        .fill_done_i  (beat_ack && last_beat),
        .fill_tag_i   (req_q.tag),
        .inval_en_i   ((state_q == COMPARE) && !req_hit_q),
        .inval_line_i (req_q.line_id),
        .clear_all_i  (flush_now)
    );

    // Controller FSM with registered core and memory outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            req_q           <= '0;
            req_hit_q       <= 1'b0;
            beat_q          <= '0;
            flush_pending_q <= 1'b0;
            cpu_ready_q     <= 1'b0;
            cpu_rdata_q     <= '0;
            mem_req_q       <= 1'b0;
            mem_addr_q      <= '0;
            hit_cnt_q       <= '0;
            miss_cnt_q      <= '0;
        end else begin
            cpu_ready_q <= 1'b0;
            if (flush && !in_idle) begin
                flush_pending_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (flush || flush_pending_q) begin
                        flush_pending_q <= 1'b0;
                    end else if (bus.cpu_req) begin
                        req_q       <= '{tag: bus.cpu_tag, line_id: bus.cpu_line_id,
                                         word_id: bus.cpu_word_id};
                        req_hit_q   <= look_hit;
                        cpu_ready_q <= look_hit;
                        cpu_rdata_q <= rd_data;
                        state_q     <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (req_hit_q) begin
                        hit_cnt_q <= hit_cnt_d;
                        state_q   <= IDLE;
                    end else begin
                        miss_cnt_q <= miss_cnt_d;
                        beat_q     <= '0;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= refill_addr(req_q.tag, req_q.line_id, '0);
                        state_q    <= REFILL;
                    end
                end
                REFILL: begin
                    if (beat_ack) begin
                        beat_q <= beat_d;
                        if (last_beat) begin
                            // The requested word may be the one arriving now
                            mem_req_q   <= 1'b0;
                            cpu_ready_q <= 1'b1;
                            cpu_rdata_q <= (req_q.word_id == WORD_W'(WORDS - 1)) ?
                                           bus.mem_rdata : rd_data;
                            state_q     <= RESP;
                        end else begin
                            mem_addr_q <= refill_addr(req_q.tag, req_q.line_id, beat_d);
                        end
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_ready = cpu_ready_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.cpu_busy  = !in_idle;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = mem_addr_q;
    assign hit_cnt       = hit_cnt_q;
    assign miss_cnt      = miss_cnt_q;

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
Direct-mapped, read-only cache controller that sits directly downstream of the cache address decoder. It consumes the decoded tag, line_id and word_id fields, performs the tag lookup and returns a 16-bit word to the core. On a miss it refills the whole 8-word line from memory, one word per beat. It also provides flush and hit/miss statistics counters.

Parameters:
- LINES, 8, number of cache lines (line_id width = 3).
- WORDS, 8, 16-bit words per line (word_id width = 3; beat counter width = 3).
- TAG_W, 25, tag width (address bits [31:7]).
- DATA_W, 16, word width (2-byte words; addr[0] is always 0).
- CNT_W, 16, statistics counter width.

Ports:
- clk  input  1  system clock; single clock domain.
- rst_n  input  1  reset; asynchronous and active-low.
- cpu_req  input  1  read request; held high until cpu_ready.
- cpu_tag  input  TAG_W  decoded tag.
- cpu_line_id  input  3  decoded line index.
- cpu_word_id  input  3  decoded word index.
- cpu_rdata  output  DATA_W  read data; valid only while cpu_ready=1.
- cpu_ready  output  1  one-cycle pulse marking a completed read.
- cpu_busy  output  1  high whenever the FSM is not in IDLE.
- flush  input  1  invalidate all lines.
- mem_req  output  1  refill beat request; held high for the whole refill.
- mem_addr  output  32  equals {tag, line_id, beat, 1'b0}.
- mem_rdata  input  DATA_W  refill data.
- mem_ack  input  1  beat transfer happens when mem_req=1 and mem_ack=1.
- hit_cnt  output  CNT_W  saturating hit counter.
- miss_cnt  output  CNT_W  saturating miss counter.

Behaviour:
- Reset (asynchronous, active-low):
  - FSM goes to IDLE and all valid bits clear.
  - Beat counter, hit_cnt and miss_cnt clear; flush_pending clears.
  - cpu_ready, cpu_busy and mem_req are 0; cpu_rdata and mem_addr are 0.
  - Tag and data arrays need no reset.
- States: IDLE, COMPARE, REFILL, RESP.
- IDLE:
  - With cpu_req=1 at a clock edge: latch tag, line_id and word_id into request registers, then go to COMPARE.
  - If flush or flush_pending is set, the flush is handled first: all valid bits clear in that cycle, flush_pending clears, and cpu_req is not sampled until the next cycle.
- COMPARE (one cycle), hit when valid[line] && tag_store[line]==req_tag:
  - Hit: cpu_ready=1, cpu_rdata=data[line][word], hit_cnt+1, then go to IDLE.
  - Hit latency is 1 cycle after the sampling edge.
  - Miss: miss_cnt+1, clear valid[line], beat=0, then go to REFILL.
- REFILL:
  - mem_req=1 and mem_addr={req_tag, req_line, beat, 1'b0}.
  - On each mem_ack: write mem_rdata to data[line][beat] and increment beat.
  - On the ack with beat==7: write tag_store[line], set valid[line], then go to RESP.
  - mem_ack may stall indefinitely; mem_req stays high and mem_addr stays stable.
  - mem_ack while mem_req=0 is ignored.
- RESP (one cycle): cpu_ready=1, cpu_rdata=data[line][word] (just written), then go to IDLE.
- cpu_ready is high for exactly one cycle per request. The requester drops cpu_req the cycle after cpu_ready unless it is issuing a new request.
- A flush asserted outside IDLE sets flush_pending. It is applied on the next IDLE cycle, before any new request. The refill in progress completes, and its line is then invalidated by the flush.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Reset during REFILL: mem_req drops immediately (asynchronously) and no partial line is left valid.
- Same line, different tag: the old line is evicted on the miss; valid is cleared before the refill starts.

Decomposition:
- Shared package cache_pkg holds:
  - LINES, WORDS, TAG_W and DATA_W localparams.
  - typedef enum logic [1:0] {IDLE, COMPARE, REFILL, RESP} cache_state_t.
  - A typedef struct cache_req_t {tag, line_id, word_id} for the latched request.
- One sub-module, cache_store, holds the tag array, valid bits and data array:
  - Combinational read; synchronous write.
  - Single-cycle clear-all-valid input for flush.
- The FSM, beat counter and statistics counters stay in cache_ctrl.

Test Plan:
- Cold miss: after reset, read addr 0x00001234 (tag 0x24, line 3, word 2). Required: mem_addr sequence 0x1230, 0x1232, …, 0x123E with data 0xA000+beat; then cpu_ready with cpu_rdata=0xA002; miss_cnt=1.
- Hit: re-read 0x1234, then 0x123E. Required: cpu_ready one cycle after each sampling edge with 0xA002 and then 0xA007; mem_req stays 0; hit_cnt=2.
- Conflict eviction: read 0x000012B4 (tag 0x25, line 3). Required: a refill at 0x12B0…0x12BE; then re-reading 0x1234 is a miss again; miss_cnt=3.
- Stalled refill: insert 5-cycle gaps between mem_ack pulses. Required: mem_addr stays stable through each gap; the final data is correct.
- Flush: assert flush mid-refill. Required: the refill completes and returns its data; the next read of the same address misses.
- Reset: assert rst_n=0 during beat 4. Required: mem_req=0 and cpu_busy=0 immediately; the next read misses; counters read 0.
- Saturation: force 2^16+3 hits. Required: hit_cnt=0xFFFF.
